ysyx_25020047_dmem_sram: RTL

Data-memory slave directly downstream of the load/store unit. It replaces the zero-latency combinational memory path with a valid/ready request/response handshake and a configurable access latency. It accepts one word-wide, byte-strobed read or write at a time and returns read data or an error flag. Backing store is an internal word array, so loads and stores become multi-cycle, as they will be once a real bus is attached.

---
 rtl/ysyx_25020047_dmem_sram_pkg.sv | 20 ++
 rtl/ysyx_25020047_dmem_sram_lfsr16.sv | 15 +
 rtl/ysyx_25020047_dmem_sram.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ysyx_25020047_dmem_sram_pkg.sv
// Shared types and constants for the data-memory SRAM slave and its delay LFSR.
package ysyx_25020047_dmem_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] BASE_DEFAULT = 32'h8000_0000;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/ysyx_25020047_dmem_sram_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to randomise access latency.
module ysyx_25020047_lfsr16
  import ysyx_25020047_dmem_sram_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr_fb(lfsr)};
  end

endmodule

// File: rtl/ysyx_25020047_dmem_sram.sv
// Word-wide byte-strobed data memory behind a valid/ready handshake with
// configurable latency; define DMEM_RAND_DELAY_EN for LFSR-randomised latency.
module ysyx_25020047_dmem_sram
  import ysyx_25020047_dmem_sram_pkg::*;
#(
  parameter int          DEPTH   = 4096,
  parameter logic [31:0] BASE    = BASE_DEFAULT,
  parameter int          LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

  state_t             state, state_nx;
  logic [3:0]         cnt, cnt_nx;
  logic [3:0]         delay_m1;
  logic               commit;

  logic               lat_wen;
  logic [31:0]        lat_addr, lat_wdata;
  logic [3:0]         lat_wstrb;

  logic               acc_wen;
  logic [31:0]        acc_addr, acc_wdata, acc_off;
  logic [3:0]         acc_wstrb;
  logic               in_range;
  logic [IDX_W-1:0]   idx;

  logic [31:0]        mem [DEPTH];

`ifdef DMEM_RAND_DELAY_EN
  logic [15:0] lfsr;

  ysyx_25020047_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  assign delay_m1 = lfsr[3:0];
`else
  assign delay_m1 = 4'(LATENCY - 1);
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // With a one-cycle delay the access commits on the accepting edge itself,
  // so the live request fields are used instead of the latched copy.
  assign acc_wen   = (state == IDLE) ? req_wen   : lat_wen;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign acc_wstrb = (state == IDLE) ? req_wstrb : lat_wstrb;

  // 33-bit compare so an array ending at 4 GiB cannot wrap
  assign in_range = ({1'b0, acc_addr} >= {1'b0, BASE}) &&
                    ({1'b0, acc_addr} <  ({1'b0, BASE} + 33'(4 * DEPTH)));
  assign acc_off  = acc_addr - BASE;
  assign idx      = IDX_W'(acc_off >> 2);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (delay_m1 == 4'd0) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = delay_m1 - 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (commit) begin
        rsp_err   <= !in_range;
        rsp_rdata <= (in_range && !acc_wen) ? mem[idx] : 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      lat_wen   <= req_wen;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wstrb <= req_wstrb;
    end
  end

  // rst_n gating keeps a request seen during reset from reaching the array
  always_ff @(posedge clk) begin
    if (commit && rst_n && acc_wen && in_range)
      mem[idx] <= merge_bytes(mem[idx], acc_wdata, acc_wstrb);
  end

endmodule
